// File: rtl/clip_controller.sv
// Two-clip record/play sequencer: button pulses drive an IDLE/RECORD/PLAY FSM that issues
// sample-rate memory strobes at {clip, offset}. Define CLIP_LOOP_EN for looping playback.
module clip_controller #(
  parameter int ADDR_W = 14
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              rec_btn,
  input  logic              play_btn,
  input  logic              stop_btn,
  input  logic              clip_sel,
  input  logic              sample_tick,
  output logic [ADDR_W:0]   mem_addr,
  output logic              mem_we,
  output logic              mem_re,
  output logic              busy,
  output logic              done,
  output logic              clipNum,
  output logic              recordOrPlay,
  output logic              led_en
);

  typedef enum logic [1:0] {IDLE, RECORD, PLAY} state_t;

  localparam logic [ADDR_W:0] ONE = 1;

  state_t                 state, state_nxt;
  logic                   clip, clip_nxt;
  logic [ADDR_W-1:0]      offset, offset_nxt;
  logic [1:0][ADDR_W:0]   len, len_nxt;
  logic [ADDR_W:0]        addr_nxt;
  logic                   we_nxt, re_nxt, done_nxt, mode_nxt;
  logic [ADDR_W:0]        count_next;

  // Samples handled so far, counting the one strobed by the current tick.
  assign count_next = {1'b0, offset} + ONE;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      clip         <= 1'b0;
      offset       <= '0;
      len          <= '0;
      mem_addr     <= '0;
      mem_we       <= 1'b0;
      mem_re       <= 1'b0;
      done         <= 1'b0;
      recordOrPlay <= 1'b0;
    end else begin
      state        <= state_nxt;
      clip         <= clip_nxt;
      offset       <= offset_nxt;
      len          <= len_nxt;
      mem_addr     <= addr_nxt;
      mem_we       <= we_nxt;
      mem_re       <= re_nxt;
      done         <= done_nxt;
      recordOrPlay <= mode_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    clip_nxt   = clip;
    offset_nxt = offset;
    len_nxt    = len;
    addr_nxt   = mem_addr;
    we_nxt     = 1'b0;
    re_nxt     = 1'b0;
    done_nxt   = 1'b0;
    mode_nxt   = recordOrPlay;

    case (state)
      IDLE: begin
        if (rec_btn) begin
          clip_nxt   = clip_sel;
          offset_nxt = '0;
          mode_nxt   = 1'b0;
          state_nxt  = RECORD;
        end else if (play_btn && (len[clip_sel] != '0)) begin
          clip_nxt   = clip_sel;
          offset_nxt = '0;
          mode_nxt   = 1'b1;
          state_nxt  = PLAY;
        end
      end

      RECORD: begin
        if (sample_tick) begin
          addr_nxt   = {clip, offset};
          we_nxt     = 1'b1;
          offset_nxt = count_next[ADDR_W-1:0];
        end
        // A tick at the last offset fills the clip; a coincident tick still counts.
        if (stop_btn || (sample_tick && (offset == '1))) begin
          len_nxt[clip] = sample_tick ? count_next : {1'b0, offset};
          done_nxt      = 1'b1;
          state_nxt     = IDLE;
        end
      end

      PLAY: begin
        if (sample_tick) begin
          addr_nxt   = {clip, offset};
          re_nxt     = 1'b1;
          offset_nxt = count_next[ADDR_W-1:0];
          if (count_next == len[clip]) begin
`ifdef CLIP_LOOP_EN
            offset_nxt = '0;
`else
            done_nxt   = 1'b1;
            state_nxt  = IDLE;
`endif
          end
        end
        if (stop_btn) begin
          done_nxt  = 1'b1;
          state_nxt = IDLE;
        end
      end

      default: state_nxt = IDLE;
    endcase
  end

  assign busy    = (state != IDLE);
  assign led_en  = busy;
  assign clipNum = clip;

endmodule
